alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side initiator for the 4-bit combinational ALU. Accepts operation requests over a valid/ready command port and queues them in a small FIFO. Issues each request to the ALU through registered opcode and operand outputs, samples the ALU's x/y results, and returns them with a tag over a valid/ready response port. Supports result chaining, where operand a is replaced by the previous result, for multi-step computations without a host round-trip.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TAG_W, 4, response tag width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command FIFO not full
- cmd_opcode  in  4  ALU opcode
- cmd_a  in  4  operand a
- cmd_b  in  4  operand b
- cmd_chain  in  1  use last captured rsp_x instead of cmd_a
- alu_opcode  out  4  registered opcode to ALU
- alu_a  out  4  registered operand a to ALU
- alu_b  out  4  registered operand b to ALU
- alu_x  in  4  ALU result low / primary
- alu_y  in  4  ALU result high / carry
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumer ready
- rsp_x  out  4  captured alu_x
- rsp_y  out  4  captured alu_y
- rsp_tag  out  TAG_W  tag of the command that produced the response
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Accept: the command is accepted when cmd_valid && cmd_ready. The entry {opcode, a, b, chain, tag} is written to the FIFO.
- Tag counter: increments on every accept and wraps from 2^TAG_W−1 to 0.
- cmd_ready = !fifo_full. It is combinational from the FIFO count only and is independent of cmd_valid.
- FSM states IDLE, DRIVE, SAMPLE, RESP.
  - IDLE: if FIFO non-empty, load alu_opcode/alu_a/alu_b from the head, pop, and go to DRIVE.
  - When chain=1, alu_a is loaded from acc, not the stored a.
  - DRIVE: ALU inputs are stable. Go to SAMPLE.
  - SAMPLE: capture alu_x/alu_y into rsp_x/rsp_y, capture the head tag into rsp_tag, update acc ← alu_x, set rsp_valid, go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid and go to IDLE.
- acc holds the x of the most recently captured response, chained or not. A chained command issued before any response uses acc = 0.
- alu_* registers hold their last values between commands and change only on the IDLE load.
- All 16 opcodes are passed through unmodified. The sequencer does not interpret opcodes.
- FIFO: circular with wrapping read/write pointers. Push and pop in the same cycle are legal and leave the count unchanged. A push while full cannot occur because cmd_ready is low.

## Timing
- Reset (async assert, sync-safe release):
  - cmd_ready=1, rsp_valid=0, rsp_x=rsp_y=0, rsp_tag=0.
  - alu_opcode=alu_a=alu_b=0, busy=0, acc=0, tag counter=0.
  - FIFO empty, FSM IDLE.
- Latency: a command accepted in cycle T with an empty FIFO and IDLE FSM is in the FIFO at T+1. The IDLE load edge ends T+1, DRIVE is T+2, SAMPLE is T+3, and rsp_valid=1 from T+4.
- Throughput: at most one command per 4 cycles, plus any rsp_ready stall cycles.
- Capacity: with rsp_ready held low, FIFO_DEPTH+1 commands are accepted (one in flight, FIFO full). cmd_ready then stays 0 until the response handshake lets IDLE pop.
- Reset mid-operation: all state returns to reset values at once. In-flight and queued commands are discarded with no response.
- rsp_ready may be held high continuously. The handshake completes in the first RESP cycle.

## Test plan
- Add with carry: opcode 1010, a=9, b=8, rsp_ready=1 → rsp_valid 4 cycles after accept, rsp_x=1, rsp_y=1, rsp_tag=0.
- Multiply: opcode 1100, a=15, b=15 → rsp_x=1, rsp_y=14 (225=0xE1). Opcode 0110, a=5, b=3 → rsp_x=1, rsp_y=0.
- Chain: add a=3, b=4 → x=7. Then add chain=1, a=0, b=5 → alu_a=7, x=12, y=0. Then xor (0101) chain=1, b=15 → x=3.
- Backpressure: rsp_ready=0, push 6 commands back-to-back → exactly 5 accepted, cmd_ready=0. rsp_x stays stable across 10 stall cycles. Release rsp_ready → responses return in order with tags 0–4, and cmd_ready returns to 1 one cycle after the first pop.
- Tag wrap: 17 commands → rsp_tag sequence 0..15, 0.
- Reset mid-op: drop rst_n during SAMPLE with 2 queued commands → rsp_valid=0 immediately. After release, no responses appear, cmd_ready=1, and the next command gets tag 0 with acc=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a 4-bit combinational ALU: queues requests, drives the ALU
// through registered operands, and returns tagged results with optional result chaining.
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic             cmd_chain,

   output logic [3:0]       alu_opcode,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   input  logic [3:0]       alu_x,
   input  logic [3:0]       alu_y,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_x,
   output logic [3:0]       rsp_y,
   output logic [TAG_W-1:0] rsp_tag,

   output logic             busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [3:0]       opcode;
      logic [3:0]       a;
      logic [3:0]       b;
      logic             chain;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_RESP
   } state_t;

   entry_t           fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic [TAG_W-1:0] tag_cnt_q;
   logic [TAG_W-1:0] cur_tag_q;
   logic [3:0]       acc_q;
   state_t           state_q;

   entry_t           wr_entry;
   entry_t           head;
   logic             push;
   logic             pop;

   assign cmd_ready = (count_q != CNT_FULL);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign busy      = (state_q != S_IDLE) || (count_q != '0);

   assign wr_entry = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, chain: cmd_chain, tag: tag_cnt_q};
   assign head     = fifo_mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Storage is left unreset; only the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tag_cnt_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
            tag_cnt_q <= tag_cnt_q + TAG_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         cur_tag_q  <= '0;
         acc_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_x      <= '0;
         rsp_y      <= '0;
         rsp_tag    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  alu_opcode <= head.opcode;
                  alu_a      <= head.chain ? acc_q : head.a;
                  alu_b      <= head.b;
                  cur_tag_q  <= head.tag;
                  state_q    <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               state_q <= S_SAMPLE;
            end
            S_SAMPLE: begin
               rsp_x     <= alu_x;
               rsp_y     <= alu_y;
               rsp_tag   <= cur_tag_q;
               acc_q     <= alu_x;
               rsp_valid <= 1'b1;
               state_q   <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer: a behavioural ALU drives alu_x/alu_y and an
// in-order reference model predicts every tagged response, including chained operands.
module tb_alu_cmd_sequencer;

   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_opcode;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic             cmd_chain;
   logic [3:0]       alu_opcode;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_x;
   logic [3:0]       alu_y;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_x;
   logic [3:0]       rsp_y;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;

   typedef struct packed {
      logic [3:0]       x;
      logic [3:0]       y;
      logic [TAG_W-1:0] tag;
      logic [3:0]       a_eff;
   } rsp_t;

   rsp_t             exp_q[$];
   rsp_t             obs_q[$];
   logic [3:0]       acc_m;
   logic [TAG_W-1:0] tag_m;
   int               total = 0;
   int               bad   = 0;

   alu_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_chain  (cmd_chain),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_x      (rsp_x),
      .rsp_y      (rsp_y),
      .rsp_tag    (rsp_tag),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; returns {y, x}
   function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] wa;
      logic [7:0] wb;
      wa = {4'h0, a};
      wb = {4'h0, b};
      case (op)
         4'b1010: return wa + wb;
         4'b1100: return wa * wb;
         4'b0110: return wa & wb;
         4'b0101: return wa ^ wb;
         default: return {op ^ b, a - b};
      endcase
   endfunction

   assign {alu_y, alu_x} = alu_fn(alu_opcode, alu_a, alu_b);

   // Reference model: commands complete strictly in acceptance order, so the chained
   // operand is simply the x result of the previously accepted command.
   task automatic model_accept(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic ch);
      logic [3:0] a_eff;
      logic [7:0] r;
      a_eff = ch ? acc_m : a;
      r     = alu_fn(op, a_eff, b);
      acc_m = r[3:0];
      exp_q.push_back({r[3:0], r[7:4], tag_m, a_eff});
      tag_m = tag_m + 1'b1;
   endtask

   task automatic model_clear();
      acc_m = '0;
      tag_m = '0;
      exp_q.delete();
      obs_q.delete();
   endtask

   // One clock: log the accept/handshake that the coming edge performs, then move to the next negedge.
   task automatic cyc();
      if (rst_n && cmd_valid && cmd_ready) model_accept(cmd_opcode, cmd_a, cmd_b, cmd_chain);
      if (rst_n && rsp_valid && rsp_ready) obs_q.push_back({rsp_x, rsp_y, rsp_tag, alu_a});
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
      int n;
      n          = 0;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_chain  = ch;
      cmd_valid  = 1'b1;
      while (cmd_ready !== 1'b1 && n < 60) begin
         cyc();
         n++;
      end
      total++;
      if (n >= 60) begin
         bad++;
         $display("FAIL send_timeout got cmd_ready=%b want 1 within 60 cycles", cmd_ready);
      end else begin
         cyc();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 40) begin
         cyc();
         k++;
      end
   endtask

   task automatic drain(input int n);
      int k;
      k         = 0;
      rsp_ready = 1'b1;
      while (obs_q.size() < n && k < 400) begin
         cyc();
         k++;
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if ({rsp_x, rsp_y} !== 8'h00) begin bad++; $display("FAIL reset_rsp_xy got=%h want=00", {rsp_x, rsp_y}); end
      total++; if (rsp_tag !== '0) begin bad++; $display("FAIL reset_rsp_tag got=%0d want=0", rsp_tag); end
      total++; if ({alu_opcode, alu_a, alu_b} !== 12'h000) begin bad++; $display("FAIL reset_alu_regs got=%h want=000", {alu_opcode, alu_a, alu_b}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin bad++; $display("FAIL reset_release got ready/busy/valid=%b want=100", {cmd_ready, busy, rsp_valid}); end
   endtask

   task automatic test_add_carry();
      int lat;
      model_clear();
      cmd_opcode = 4'b1010;
      cmd_a      = 4'd9;
      cmd_b      = 4'd8;
      cmd_chain  = 1'b0;
      cmd_valid  = 1'b1;
      rsp_ready  = 1'b1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b want=1", cmd_ready); end
      cyc();
      cmd_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b want=1", busy); end
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 12) begin
         cyc();
         lat++;
      end
      total++; if (lat != 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
      total++; if ({rsp_x, rsp_y} !== 8'h11) begin bad++; $display("FAIL add_xy got=%h want=11", {rsp_x, rsp_y}); end
      total++; if (rsp_tag !== '0) begin bad++; $display("FAIL add_tag got=%0d want=0", rsp_tag); end
      cyc();
      total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL add_done got valid/busy=%b want=00", {rsp_valid, busy}); end
      total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL add_model got n=%0d want n=1 rsp=%h", obs_q.size(), exp_q[0]); end
   endtask

   task automatic test_mult();
      rsp_t o;
      model_clear();
      tag_m = TAG_W'(1);
      send(4'b1100, 4'd15, 4'd15, 1'b0);
      send(4'b0110, 4'd5, 4'd3, 1'b0);
      drain(2);
      total++; if (obs_q.size() != 2) begin bad++; $display("FAIL mult_count got=%0d want=2", obs_q.size()); end
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      total++; if ({o.x, o.y} !== 8'h1E) begin bad++; $display("FAIL mult_15x15 got x=%0d y=%0d want x=1 y=14", o.x, o.y); end
      o = (obs_q.size() > 1) ? obs_q[1] : '0;
      total++; if ({o.x, o.y} !== 8'h10) begin bad++; $display("FAIL and_5_3 got x=%0d y=%0d want x=1 y=0", o.x, o.y); end
      foreach (exp_q[i]) begin
         o = (i < obs_q.size()) ? obs_q[i] : '0;
         total++; if (o !== exp_q[i]) begin bad++; $display("FAIL mult_rsp%0d got=%h want=%h", i, o, exp_q[i]); end
      end
   endtask

   task automatic test_chain();
      rsp_t o;
      obs_q.delete();
      exp_q.delete();
      rsp_ready = 1'b1;
      send(4'b1010, 4'd3, 4'd4, 1'b0);
      drain(1);
      send(4'b1010, 4'd0, 4'd5, 1'b1);
      wait_rsp();
      total++; if (alu_a !== 4'd7) begin bad++; $display("FAIL chain1_alu_a got=%0d want=7", alu_a); end
      total++; if ({rsp_valid, rsp_x, rsp_y} !== {1'b1, 4'd12, 4'd0}) begin bad++; $display("FAIL chain1_rsp got v=%b x=%0d y=%0d want v=1 x=12 y=0", rsp_valid, rsp_x, rsp_y); end
      cyc();
      send(4'b0101, 4'($urandom), 4'd15, 1'b1);
      wait_rsp();
      total++; if ({alu_a, rsp_x} !== {4'd12, 4'd3}) begin bad++; $display("FAIL chain2_xor got a=%0d x=%0d want a=12 x=3", alu_a, rsp_x); end
      cyc();
      total++; if (obs_q.size() != 3) begin bad++; $display("FAIL chain_count got=%0d want=3", obs_q.size()); end
      foreach (exp_q[i]) begin
         o = (i < obs_q.size()) ? obs_q[i] : '0;
         total++; if (o !== exp_q[i]) begin bad++; $display("FAIL chain_rsp%0d got=%h want=%h", i, o, exp_q[i]); end
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int   acc_n;
      logic [3:0] hx, hy;
      logic [TAG_W-1:0] ht;
      rsp_t o;
      apply_reset();
      rsp_ready = 1'b0;
      acc_n     = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_opcode = 4'($urandom);
         cmd_a      = 4'($urandom);
         cmd_b      = 4'($urandom);
         cmd_chain  = 1'($urandom);
         cmd_valid  = 1'b1;
         if (cmd_ready === 1'b1) acc_n++;
         cyc();
      end
      cmd_valid = 1'b0;
      total++; if (acc_n != FIFO_DEPTH + 1) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_n, FIFO_DEPTH + 1); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", cmd_ready); end
      wait_rsp();
      hx = rsp_x;
      hy = rsp_y;
      ht = rsp_tag;
      for (int i = 0; i < 10; i++) begin
         cyc();
         total++; if ({rsp_valid, rsp_x, rsp_y, rsp_tag} !== {1'b1, hx, hy, ht}) begin bad++; $display("FAIL bp_hold%0d got v=%b x=%h y=%h t=%h want v=1 x=%h y=%h t=%h", i, rsp_valid, rsp_x, rsp_y, rsp_tag, hx, hy, ht); end
      end
      rsp_ready = 1'b1;
      cyc();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_before_pop got=%b want=0", cmd_ready); end
      cyc();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", cmd_ready); end
      drain(5);
      total++; if (obs_q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", obs_q.size()); end
      foreach (exp_q[i]) begin
         o = (i < obs_q.size()) ? obs_q[i] : '0;
         total++; if (o.tag !== TAG_W'(i) || o !== exp_q[i]) begin bad++; $display("FAIL bp_rsp%0d got=%h want=%h tag=%0d", i, o, exp_q[i], i); end
      end
   endtask

   task automatic test_tag_wrap();
      rsp_t o;
      apply_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      end
      drain(17);
      total++; if (obs_q.size() != 17) begin bad++; $display("FAIL wrap_count got=%0d want=17", obs_q.size()); end
      foreach (exp_q[i]) begin
         o = (i < obs_q.size()) ? obs_q[i] : '0;
         total++; if (o.tag !== TAG_W'(i % 16) || o !== exp_q[i]) begin bad++; $display("FAIL wrap_rsp%0d got=%h want=%h tag=%0d", i, o, exp_q[i], i % 16); end
      end
   endtask

   task automatic test_reset_midop();
      rsp_t o;
      obs_q.delete();
      exp_q.delete();
      rsp_ready = 1'b1;
      send(4'b1010, 4'd7, 4'd0, 1'b0);
      drain(1);
      for (int i = 0; i < 3; i++) begin
         cmd_opcode = 4'($urandom);
         cmd_a      = 4'($urandom);
         cmd_b      = 4'($urandom);
         cmd_chain  = 1'($urandom);
         cmd_valid  = 1'b1;
         cyc();
      end
      cmd_valid = 1'b0;
      // First of the three is now in SAMPLE with the other two queued.
      total++; if ({busy, rsp_valid, cmd_ready} !== 3'b101) begin bad++; $display("FAIL midop_pre got busy/valid/ready=%b want=101", {busy, rsp_valid, cmd_ready}); end
      rst_n = 1'b0;
      #1;
      total++; if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin bad++; $display("FAIL midop_async got busy/valid/ready=%b want=001", {busy, rsp_valid, cmd_ready}); end
      total++; if ({alu_opcode, alu_a, alu_b, rsp_x, rsp_y} !== 20'h0) begin bad++; $display("FAIL midop_regs got=%h want=00000", {alu_opcode, alu_a, alu_b, rsp_x, rsp_y}); end
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 20; i++) cyc();
      total++; if (obs_q.size() != 0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midop_ghost got n=%0d valid=%b want n=0 valid=0", obs_q.size(), rsp_valid); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midop_ready got=%b want=1", cmd_ready); end
      send(4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      wait_rsp();
      total++; if ({rsp_tag, alu_a} !== {TAG_W'(0), 4'd0}) begin bad++; $display("FAIL midop_next got tag=%0d alu_a=%0d want tag=0 alu_a=0", rsp_tag, alu_a); end
      cyc();
      o = (obs_q.size() > 0) ? obs_q[0] : '0;
      total++; if (obs_q.size() != 1 || o !== exp_q[0]) begin bad++; $display("FAIL midop_model got n=%0d rsp=%h want n=1 rsp=%h", obs_q.size(), o, exp_q[0]); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_opcode = '0;
      cmd_a      = '0;
      cmd_b      = '0;
      cmd_chain  = 1'b0;
      rsp_ready  = 1'b0;
      acc_m      = '0;
      tag_m      = '0;
      test_reset();
      test_add_carry();
      test_mult();
      test_chain();
      test_backpressure();
      test_tag_wrap();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
